// File: rtl/wb_initiator_if.sv
// Wishbone pipelined-mode bus bundle shared by the initiator and its slaves.
// With NO_MODPORT_EXPRESSIONS the data buses are named dat_m/dat_s, otherwise dat_o/dat_i.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        ack;
    logic        stall;

`ifdef NO_MODPORT_EXPRESSIONS
    logic [31:0] dat_m;
    logic [31:0] dat_s;

    modport master (output cyc, stb, we, adr, sel, dat_m, input  dat_s, ack, stall);
    modport slave  (input  cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall);
`else
    logic [31:0] dat_o;
    logic [31:0] dat_i;

    modport master (output cyc, stb, we, adr, sel, dat_o, input  dat_i, ack, stall);
    modport slave  (input  cyc, stb, we, adr, sel, dat_o, output dat_i, ack, stall);
`endif
endinterface

// File: rtl/wb_initiator.sv
// Wishbone pipelined-mode initiator: one valid/ready request becomes one bus cycle.
// Optional WBM_TIMEOUT_EN aborts a cycle left open for TIMEOUT clocks; see if_wb for NO_MODPORT_EXPRESSIONS.
module wb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    if_wb.master        bus,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_dat,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT must be within 2..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q;
    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_dat_q;
    logic        rsp_err_q;
    logic [31:0] rd_data;
    logic        timed_out;

`ifdef NO_MODPORT_EXPRESSIONS
    assign bus.dat_m = dat_q;
    assign rd_data   = bus.dat_s;
`else
    assign bus.dat_o = dat_q;
    assign rd_data   = bus.dat_i;
`endif

`ifdef WBM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q;
    assign timed_out = (cnt_q == TIMEOUT_LAST);
`else
    assign timed_out = 1'b0;
`endif

    assign bus.cyc   = cyc_q;
    assign bus.stb   = stb_q;
    assign bus.we    = we_q;
    assign bus.adr   = adr_q;
    assign bus.sel   = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
`ifdef WBM_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    // Decoded straight from the state register so a request can be taken right after reset.
    assign req_ready = (state_q == S_IDLE);

    // NOTE: the asynchronous reset sits in the sensitivity list so cyc/stb fall without a clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        adr_q   <= req_adr;
                        sel_q   <= req_sel;
                        dat_q   <= req_dat;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
`ifdef WBM_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                end

                S_REQ, S_WAIT: begin
`ifdef WBM_TIMEOUT_EN
                    cnt_q <= cnt_q + 16'd1;
`endif
                    // An ack is a completion even while stall is still high.
                    if (bus.ack) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= we_q ? 32'h0 : rd_data;
                        rsp_err_q   <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (timed_out) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= 32'h0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (state_q == S_REQ && !bus.stall) begin
                        stb_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed scenarios plus randomized transfers
// against a scripted slave whose stall/ack schedule defines the expected timing.
module tb_wb_initiator;

    localparam int unsigned TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        auto_s;
    logic        ack_m;
    logic        stall_m;
    logic [31:0] dat_m;
    logic [31:0] bus_wdat;
    logic [31:0] slave_rdat;

    int checks = 0;
    int errors = 0;

    if_wb bus ();

    wb_initiator #(.TIMEOUT(TO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_sel   (req_sel),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err)
    );

    always #5 clk_i = ~clk_i;

`ifdef NO_MODPORT_EXPRESSIONS
    assign bus_wdat  = bus.dat_m;
    assign bus.dat_s = slave_rdat;
`else
    assign bus_wdat  = bus.dat_o;
    assign bus.dat_i = slave_rdat;
`endif

    // Slave contents for the zero-wait responder: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    always_comb begin
        bus.ack    = auto_s ? (bus.cyc & bus.stb) : ack_m;
        bus.stall  = auto_s ? 1'b0 : stall_m;
        slave_rdat = auto_s ? mem_word(bus.adr) : dat_m;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transfer against a slave that stalls s cycles, then acks d cycles after stall drops.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] wdat, input int s, input int d, input logic [31:0] rdat);
        logic [31:0] exp_dat;
        exp_dat = we ? 32'h0 : rdat;
        auto_s  = 1'b0;
        stall_m = 1'b0;
        ack_m   = 1'b0;
        dat_m   = $urandom;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL txn_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_sel   = sel;
        req_dat   = wdat;
        @(posedge clk_i); @(negedge clk_i);
        req_valid = 1'b0;
        req_we    = ~we;
        req_adr   = $urandom;
        req_sel   = ~sel;
        req_dat   = $urandom;
        for (int i = 0; i <= s; i++) begin
            stall_m = (i < s);
            ack_m   = (i == s) && (d == 0);
            dat_m   = ack_m ? rdat : $urandom;
            checks++;
            if ({bus.cyc, bus.stb, rsp_valid, req_ready} !== 4'b1100) begin
                errors++;
                $display("FAIL txn_req_ctrl: got %b expected 1100", {bus.cyc, bus.stb, rsp_valid, req_ready});
            end
            checks++;
            if ({bus.we, bus.adr, bus.sel, bus_wdat} !== {we, adr, sel, wdat}) begin
                errors++;
                $display("FAIL txn_req_fields: got %h expected %h",
                         {bus.we, bus.adr, bus.sel, bus_wdat}, {we, adr, sel, wdat});
            end
            @(posedge clk_i); @(negedge clk_i);
        end
        for (int j = 1; j <= d; j++) begin
            stall_m = 1'b0;
            ack_m   = (j == d);
            dat_m   = ack_m ? rdat : $urandom;
            checks++;
            if ({bus.cyc, bus.stb, rsp_valid} !== 3'b100) begin
                errors++;
                $display("FAIL txn_wait_ctrl: got %b expected 100", {bus.cyc, bus.stb, rsp_valid});
            end
            @(posedge clk_i); @(negedge clk_i);
        end
        ack_m = 1'b0;
        dat_m = $urandom;
        checks++;
        if ({bus.cyc, bus.stb, rsp_valid, rsp_err} !== 4'b0010) begin
            errors++;
            $display("FAIL txn_done_ctrl: got %b expected 0010", {bus.cyc, bus.stb, rsp_valid, rsp_err});
        end
        checks++;
        if (rsp_dat !== exp_dat) begin
            errors++;
            $display("FAIL txn_rsp_dat: got %h expected %h", rsp_dat, exp_dat);
        end
        @(posedge clk_i); @(negedge clk_i);
        checks++;
        if ({rsp_valid, req_ready, bus.cyc} !== 3'b010) begin
            errors++;
            $display("FAIL txn_idle_ctrl: got %b expected 010", {rsp_valid, req_ready, bus.cyc});
        end
        checks++;
        if (rsp_dat !== exp_dat) begin
            errors++;
            $display("FAIL txn_rsp_hold: got %h expected %h", rsp_dat, exp_dat);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #2;
        checks++;
        if ({bus.cyc, bus.stb, bus.we, bus.adr, bus.sel, bus_wdat, rsp_valid, rsp_dat, rsp_err, req_ready}
            !== {104'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_in: got %h expected 1",
                     {bus.cyc, bus.stb, bus.we, bus.adr, bus.sel, bus_wdat, rsp_valid, rsp_dat, rsp_err, req_ready});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({bus.cyc, bus.stb, rsp_valid, rsp_err, req_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_out: got %b expected 00001", {bus.cyc, bus.stb, rsp_valid, rsp_err, req_ready});
        end
    endtask

    task automatic test_read_zero_wait();
        run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 0, 32'hDEAD_BEEF);
    endtask

    task automatic test_write_stall();
        run_txn(1'b1, 32'h0000_0004, 4'b0011, 32'h1234_5678, 3, 2, 32'hFFFF_FFFF);
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_adr[$];
        logic [31:0] got_dat[$];
        int idx = 0;
        int rises = 0;
        int cyc_hi = 0;
        logic prev_ready;
        logic prev_cyc;
        auto_s    = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_sel   = 4'hF;
        req_adr   = 32'h0;
        prev_ready = req_ready;
        prev_cyc   = bus.cyc;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i); @(negedge clk_i);
            if (bus.cyc && bus.stb) got_adr.push_back(bus.adr);
            if (bus.cyc) cyc_hi++;
            if (bus.cyc && !prev_cyc) rises++;
            if (rsp_valid) got_dat.push_back(rsp_dat);
            if (prev_ready && req_valid && !req_ready) begin
                idx++;
                if (idx < 4) req_adr = 32'(idx * 4);
                else req_valid = 1'b0;
            end
            prev_ready = req_ready;
            prev_cyc   = bus.cyc;
        end
        auto_s = 1'b0;
        checks++;
        if (got_adr.size() != 4 || rises != 4 || cyc_hi != 4) begin
            errors++;
            $display("FAIL b2b_count: got adr=%0d rises=%0d cyc_hi=%0d expected 4 4 4",
                     got_adr.size(), rises, cyc_hi);
        end
        checks++;
        if (got_dat.size() != 4) begin
            errors++;
            $display("FAIL b2b_rsp_count: got %0d expected 4", got_dat.size());
        end
        for (int k = 0; k < 4; k++) begin
            if (k < got_adr.size()) begin
                checks++;
                if (got_adr[k] !== 32'(k * 4)) begin
                    errors++;
                    $display("FAIL b2b_adr%0d: got %h expected %h", k, got_adr[k], 32'(k * 4));
                end
            end
            if (k < got_dat.size()) begin
                checks++;
                if (got_dat[k] !== mem_word(32'(k * 4))) begin
                    errors++;
                    $display("FAIL b2b_dat%0d: got %h expected %h", k, got_dat[k], mem_word(32'(k * 4)));
                end
            end
        end
    endtask

    task automatic test_stray_ack();
        auto_s  = 1'b0;
        stall_m = 1'b0;
        ack_m   = 1'b1;
        dat_m   = 32'hBAD0_BAD0;
        @(posedge clk_i); @(negedge clk_i);
        ack_m = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, bus.cyc} !== 3'b010) begin
            errors++;
            $display("FAIL stray_ack: got %b expected 010", {rsp_valid, req_ready, bus.cyc});
        end
        @(posedge clk_i); @(negedge clk_i);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_late: got %b expected 0", rsp_valid);
        end
        run_txn(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1, 1, 32'h0BAD_F00D);
    endtask

`ifdef WBM_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        auto_s    = 1'b0;
        stall_m   = 1'b0;
        ack_m     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h0000_0100;
        req_sel   = 4'hF;
        @(posedge clk_i); @(negedge clk_i);
        req_valid = 1'b0;
        while (bus.cyc && n < int'(TO) + 4) begin
            n++;
            @(posedge clk_i); @(negedge clk_i);
        end
        checks++;
        if (n != int'(TO)) begin
            errors++;
            $display("FAIL timeout_len: got %0d expected %0d", n, TO);
        end
        checks++;
        if ({rsp_valid, rsp_err, bus.cyc, bus.stb, rsp_dat} !== {4'b1100, 32'h0}) begin
            errors++;
            $display("FAIL timeout_rsp: got %h expected %h", {rsp_valid, rsp_err, bus.cyc, bus.stb, rsp_dat},
                     {4'b1100, 32'h0});
        end
        @(posedge clk_i); @(negedge clk_i);
        run_txn(1'b0, 32'h0000_0104, 4'hF, 32'h0, 0, 1, 32'h7777_1111);
    endtask
`else
    task automatic test_no_timeout();
        logic held = 1'b1;
        auto_s    = 1'b0;
        stall_m   = 1'b0;
        ack_m     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h0000_0100;
        req_sel   = 4'hF;
        @(posedge clk_i); @(negedge clk_i);
        req_valid = 1'b0;
        for (int c = 0; c < 5 * int'(TO); c++) begin
            if (!(bus.cyc === 1'b1 && rsp_valid === 1'b0)) held = 1'b0;
            @(posedge clk_i); @(negedge clk_i);
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout_hold: got %b expected 1", held);
        end
        ack_m = 1'b1;
        dat_m = 32'hCAFE_F00D;
        @(posedge clk_i); @(negedge clk_i);
        ack_m = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, bus.cyc, rsp_dat} !== {3'b100, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL no_timeout_rsp: got %h expected %h", {rsp_valid, rsp_err, bus.cyc, rsp_dat},
                     {3'b100, 32'hCAFE_F00D});
        end
        @(posedge clk_i); @(negedge clk_i);
    endtask
`endif

    task automatic test_reset_mid_cycle();
        logic quiet = 1'b1;
        auto_s    = 1'b0;
        stall_m   = 1'b0;
        ack_m     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h0000_0020;
        req_sel   = 4'hF;
        @(posedge clk_i); @(negedge clk_i);
        req_valid = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        checks++;
        if ({bus.cyc, bus.stb} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_wait: got %b expected 10", {bus.cyc, bus.stb});
        end
        #1 rst_i = 1'b1;
        #1;
        checks++;
        if ({bus.cyc, bus.stb, rsp_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_async: got %b expected 0001", {bus.cyc, bus.stb, rsp_valid, req_ready});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        ack_m = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); @(negedge clk_i);
            ack_m = 1'b0;
            if (!(rsp_valid === 1'b0 && req_ready === 1'b1 && bus.cyc === 1'b0)) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_quiet: got %b expected 1", quiet);
        end
        run_txn(1'b0, 32'h0000_0024, 4'hF, 32'h0, 0, 0, 32'h2468_ACE0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)),
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        auto_s    = 1'b0;
        ack_m     = 1'b0;
        stall_m   = 1'b0;
        dat_m     = '0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = '0;
        req_sel   = '0;
        req_dat   = '0;
        test_reset();
        test_read_zero_wait();
        test_write_stall();
        test_back_to_back();
        test_stray_ack();
`ifdef WBM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_cycle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone pipelined-mode bus master: the initiator end of the bus that the team's peripheral slaves (timer, UART, etc.) respond to.
- Converts a simple valid/ready single-word request port into one complete Wishbone cycle. Returns read data (or a write completion) on a one-cycle response strobe.
- Used by CPU load/store units, debug bridges and boot loaders to reach slave peripherals.
- One outstanding transaction at a time.

Parameters:
- TIMEOUT, 255: number of clk_i cycles a bus cycle may stay open before it is aborted. Only used when WBM_TIMEOUT_EN is defined. Legal range 2..65535.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- bus  if_wb.master  -  Wishbone master side: cyc, stb, we, adr[31:0], sel[3:0], write data out, read data in, ack, stall.
  - Write data is driven on bus.dat_o, or on bus.dat_m when NO_MODPORT_EXPRESSIONS is defined.
  - Read data is taken from bus.dat_i, or from bus.dat_s when NO_MODPORT_EXPRESSIONS is defined.
- req_valid  input  1  request present
- req_ready  output  1  request accepted when valid&ready
- req_we  input  1  1=write, 0=read
- req_adr  input  32  byte address
- req_sel  input  4  byte lane enables
- req_dat  input  32  write data
- rsp_valid  output  1  one-cycle completion strobe
- rsp_dat  output  32  read data (0 for writes)
- rsp_err  output  1  completion was a timeout abort; constant 0 without WBM_TIMEOUT_EN

Behaviour:
- Reset values: cyc=0, stb=0, we=0, adr=0, sel=0, write data=0, rsp_valid=0, rsp_dat=0, rsp_err=0, state=S_IDLE, timeout counter=0.
- All bus outputs and response outputs are registered.
- req_ready = (state==S_IDLE) and is combinational from state, so it is 1 immediately after reset.
- States:
  - S_IDLE: on req_valid&req_ready, latch we/adr/sel/dat, set cyc=1 and stb=1, and go to S_REQ. Otherwise cyc=stb=0.
  - S_REQ: cyc=1, stb=1. Hold adr, we, sel and data stable while stall=1.
    - If stall=0 and ack=1 in the same cycle: capture read data, go to S_DONE.
    - If stall=0 and ack=0: drop stb, go to S_WAIT.
  - S_WAIT: cyc=1, stb=0. On ack: capture read data into rsp_dat (write: rsp_dat=0), go to S_DONE.
  - S_DONE: cyc=0, rsp_valid=1 for exactly this one cycle, then go to S_IDLE.
- Latency:
  - stb rises 1 cycle after request acceptance.
  - rsp_valid rises 1 cycle after the ack cycle.
  - Minimum request-to-request spacing is 3 cycles (IDLE, REQ with immediate ack, DONE).
- Ack arriving in S_IDLE or S_DONE (stray) is ignored; no response is generated.
- Ack while stall=1 in S_REQ is treated as a completion (go to S_DONE). This tolerates slaves that ack before deasserting stall.
- Read data is sampled only on the ack cycle. rsp_dat holds its value until the next completion.
- rst_i asserted mid-cycle: cyc and stb drop immediately (asynchronous), no response is issued, and the pending request is lost.
- req_* inputs are ignored outside S_IDLE.

Optional Feature:
- Macro WBM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to S_REQ and increments each cycle in S_REQ or S_WAIT.
  - When the counter reaches TIMEOUT-1 without ack, the next cycle drops cyc/stb, goes to S_DONE with rsp_err=1 and rsp_dat=0.
  - An ack in the same cycle the limit is reached wins: normal completion with rsp_err=0.
  - rsp_err is cleared on every normal completion.
- Not defined: no counter; the master waits indefinitely for ack; rsp_err is tied to 0.

Test Plan:
1. Read, zero-wait: slave with stall=0 that acks on the same cycle stb is seen, data 32'hDEADBEEF. Issue a read to adr 32'h0000_0010 → stb high 1 cycle, rsp_valid 2 cycles after acceptance, rsp_dat=DEADBEEF, req_ready back to 1 the following cycle.
2. Write with stall: stall=1 for 3 cycles, then ack 2 cycles after stall drops. Write adr 32'h4, sel 4'b0011, dat 32'h1234_5678 → adr/sel/dat stable during all 3 stall cycles; stb drops after the accept, cyc stays high until ack; rsp_valid pulses once; rsp_dat=0.
3. Back-to-back: req_valid held high with 4 reads to addresses 0,4,8,C → exactly 4 bus cycles in address order; cyc is low for at least one cycle between transfers; 4 rsp_valid pulses with matching data.
4. Stray ack: pulse ack in S_IDLE → no rsp_valid, no state change; the next request completes normally.
5. Timeout (WBM_TIMEOUT_EN, TIMEOUT=8): slave never acks → cyc drops after 8 cycles; rsp_valid=1 with rsp_err=1 and rsp_dat=0. A following read to a responsive slave returns rsp_err=0.
6. Reset mid-cycle: assert rst_i while in S_WAIT → cyc, stb and rsp_valid go to 0 without a clock edge. After release, req_ready=1 and no spurious rsp_valid appears.
